// File: rtl/calendar_rtc.sv
// calendar_rtc: BCD calendar clock with prescaler, external load and button editing.
// Define CALENDAR_RTC_ALARM_EN to add the editable alarm (fields 6/7) and alarm_hit.
module calendar_rtc #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned TICK_DIV = CLK_HZ,
    parameter logic [15:0] YEAR_RST = 16'h2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_year_bcd,
    input  logic [7:0]  load_month_bcd,
    input  logic [7:0]  load_day_bcd,
    input  logic [7:0]  load_hour_bcd,
    input  logic [7:0]  load_minute_bcd,
    input  logic [7:0]  load_second_bcd,
    input  logic        mode_btn,
    input  logic        adjust_btn,
    input  logic        up_btn,
    input  logic        down_btn,
    input  logic        alarm_on,
    output logic [15:0] year_bcd,
    output logic [7:0]  month_bcd,
    output logic [7:0]  day_bcd,
    output logic [7:0]  hour_bcd,
    output logic [7:0]  minute_bcd,
    output logic [7:0]  second_bcd,
    output logic        sec_tick,
    output logic        edit_active,
    output logic [2:0]  edit_field,
    output logic        alarm_hit
);
    typedef enum logic {RUN, EDIT} state_t;
`ifdef CALENDAR_RTC_ALARM_EN
    localparam logic [2:0] LAST_FIELD = 3'd7;
    logic [7:0] alarm_hour, alarm_minute, alarm_hour_n, alarm_minute_n;
    logic       alarm_hit_n;
`else
    localparam logic [2:0] LAST_FIELD = 3'd5;
    logic unused_alarm_on;
    assign unused_alarm_on = alarm_on;
    assign alarm_hit = 1'b0;
`endif
    state_t      state, state_n;
    logic [31:0] presc, presc_n;
    logic [15:0] year_n;
    logic [7:0]  month_n, day_n, hour_n, minute_n, second_n, cur_len;
    logic [2:0]  field_n;
    logic        tick_n, up, dn;

    function automatic logic [15:0] inc_bcd(input logic [15:0] v);
        logic [15:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                c = r[4*i+:4] == 4'd9;
                r[4*i+:4] = c ? 4'd0 : r[4*i+:4] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [15:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                c = r[4*i+:4] == 4'd0;
                r[4*i+:4] = c ? 4'd9 : r[4*i+:4] - 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic u, input logic d);
        logic [15:0] i, e;
        i = inc_bcd({8'h00, v});
        e = dec_bcd({8'h00, v});
        return u ? (v >= hi ? lo : i[7:0]) : d ? (v <= lo ? hi : e[7:0]) : v;
    endfunction

    // Two BCD digits divisible by 4: even tens needs units 0/4/8, odd tens needs 2/6.
    function automatic logic div4(input logic [7:0] v);
        return v[4] ? (v[3:0] == 4'd2 || v[3:0] == 4'd6)
                    : (v[3:0] == 4'd0 || v[3:0] == 4'd4 || v[3:0] == 4'd8);
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] m, input logic [15:0] y);
        logic leap;
        leap = div4(y[7:0]) && (y[7:0] != 8'h00 || div4(y[15:8]));
        return m == 8'h02 ? (leap ? 8'h29 : 8'h28)
             : (m == 8'h04 || m == 8'h06 || m == 8'h09 || m == 8'h11) ? 8'h30 : 8'h31;
    endfunction

    assign up      = up_btn & ~down_btn;
    assign dn      = down_btn & ~up_btn;
    assign cur_len = month_len(month_bcd, year_bcd);

    always_comb begin
        state_n = load ? RUN : adjust_btn ? (state == RUN ? EDIT : RUN) : state;
    end

    always_comb begin
        edit_active = state == EDIT;
    end

    always_comb begin
        year_n   = year_bcd;
        month_n  = month_bcd;
        day_n    = day_bcd;
        hour_n   = hour_bcd;
        minute_n = minute_bcd;
        second_n = second_bcd;
        presc_n  = presc;
        field_n  = edit_field;
        tick_n   = 1'b0;
`ifdef CALENDAR_RTC_ALARM_EN
        alarm_hour_n   = alarm_hour;
        alarm_minute_n = alarm_minute;
        alarm_hit_n    = 1'b0;
`endif
        if (load) begin
            {year_n, month_n, day_n} = {load_year_bcd, load_month_bcd, load_day_bcd};
            {hour_n, minute_n, second_n} = {load_hour_bcd, load_minute_bcd, load_second_bcd};
            presc_n = '0;
        end else if (state == RUN) begin
            if (adjust_btn) begin
                presc_n = '0;
                field_n = 3'd0;
            end else if (presc == TICK_DIV - 1) begin
                presc_n  = '0;
                tick_n   = 1'b1;
                second_n = bcd_step(second_bcd, 8'h00, 8'h59, 1'b1, 1'b0);
                if (second_bcd >= 8'h59) begin
                    minute_n = bcd_step(minute_bcd, 8'h00, 8'h59, 1'b1, 1'b0);
                    if (minute_bcd >= 8'h59) begin
                        hour_n = bcd_step(hour_bcd, 8'h00, 8'h23, 1'b1, 1'b0);
                        if (hour_bcd >= 8'h23) begin
                            day_n = bcd_step(day_bcd, 8'h01, cur_len, 1'b1, 1'b0);
                            if (day_bcd >= cur_len) begin
                                month_n = bcd_step(month_bcd, 8'h01, 8'h12, 1'b1, 1'b0);
                                if (month_bcd >= 8'h12)
                                    year_n = inc_bcd(year_bcd);
                            end
                        end
                    end
                end
`ifdef CALENDAR_RTC_ALARM_EN
                alarm_hit_n = alarm_on && second_n == 8'h00 && minute_n == alarm_minute
                              && hour_n == alarm_hour;
`endif
            end else begin
                presc_n = presc + 32'd1;
            end
        end else begin
            presc_n = '0;
            if (!adjust_btn) begin
                if (mode_btn)
                    field_n = edit_field == LAST_FIELD ? 3'd0 : edit_field + 3'd1;
                case (edit_field)
                    3'd0: year_n   = up ? inc_bcd(year_bcd) : dn ? dec_bcd(year_bcd) : year_bcd;
                    3'd1: month_n  = bcd_step(month_bcd, 8'h01, 8'h12, up, dn);
                    3'd2: day_n    = bcd_step(day_bcd, 8'h01, cur_len, up, dn);
                    3'd3: hour_n   = bcd_step(hour_bcd, 8'h00, 8'h23, up, dn);
                    3'd4: minute_n = bcd_step(minute_bcd, 8'h00, 8'h59, up, dn);
                    3'd5: second_n = bcd_step(second_bcd, 8'h00, 8'h59, up, dn);
`ifdef CALENDAR_RTC_ALARM_EN
                    3'd6: alarm_hour_n   = bcd_step(alarm_hour, 8'h00, 8'h23, up, dn);
                    3'd7: alarm_minute_n = bcd_step(alarm_minute, 8'h00, 8'h59, up, dn);
`endif
                    default: ;
                endcase
            end
        end
        // Any year/month change (load, edit or carry) keeps day inside the new month.
        day_n = day_n > month_len(month_n, year_n) ? month_len(month_n, year_n) : day_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            year_bcd   <= YEAR_RST;
            month_bcd  <= 8'h01;
            day_bcd    <= 8'h01;
            hour_bcd   <= 8'h00;
            minute_bcd <= 8'h00;
            second_bcd <= 8'h00;
            presc      <= '0;
            edit_field <= 3'd0;
            sec_tick   <= 1'b0;
        end else begin
            state      <= state_n;
            year_bcd   <= year_n;
            month_bcd  <= month_n;
            day_bcd    <= day_n;
            hour_bcd   <= hour_n;
            minute_bcd <= minute_n;
            second_bcd <= second_n;
            presc      <= presc_n;
            edit_field <= field_n;
            sec_tick   <= tick_n;
        end
    end

`ifdef CALENDAR_RTC_ALARM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_hour   <= 8'h00;
            alarm_minute <= 8'h00;
            alarm_hit    <= 1'b0;
        end else begin
            alarm_hour   <= alarm_hour_n;
            alarm_minute <= alarm_minute_n;
            alarm_hit    <= alarm_hit_n;
        end
    end
`endif
endmodule

// File: tb/tb_calendar_rtc.sv
// tb_calendar_rtc: directed checks of calendar_rtc with TICK_DIV=4.
module tb_calendar_rtc;
`ifdef CALENDAR_RTC_ALARM_EN
    localparam int NF = 8;
`else
    localparam int NF = 6;
`endif
    logic        clk = 1'b0;
    logic        reset_n, load, mode_btn, adjust_btn, up_btn, down_btn, alarm_on;
    logic [15:0] load_year_bcd, year_bcd;
    logic [7:0]  load_month_bcd, load_day_bcd, load_hour_bcd, load_minute_bcd, load_second_bcd;
    logic [7:0]  month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;
    logic        sec_tick, edit_active, alarm_hit;
    logic [2:0]  edit_field;
    int          errors = 0, checks = 0, ticks = 0, t0;

    calendar_rtc #(.TICK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .load(load),
        .load_year_bcd(load_year_bcd), .load_month_bcd(load_month_bcd),
        .load_day_bcd(load_day_bcd), .load_hour_bcd(load_hour_bcd),
        .load_minute_bcd(load_minute_bcd), .load_second_bcd(load_second_bcd),
        .mode_btn(mode_btn), .adjust_btn(adjust_btn), .up_btn(up_btn), .down_btn(down_btn),
        .alarm_on(alarm_on),
        .year_bcd(year_bcd), .month_bcd(month_bcd), .day_bcd(day_bcd),
        .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
        .sec_tick(sec_tick), .edit_active(edit_active), .edit_field(edit_field),
        .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (sec_tick) ticks++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic m, input logic a, input logic u, input logic d);
        {mode_btn, adjust_btn, up_btn, down_btn} = {m, a, u, d};
        cyc(1);
        {mode_btn, adjust_btn, up_btn, down_btn} = 4'b0;
    endtask

    task automatic do_load(input logic [55:0] t, input logic u);
        {load_year_bcd, load_month_bcd, load_day_bcd} = t[55:24];
        {load_hour_bcd, load_minute_bcd, load_second_bcd} = t[23:0];
        load = 1'b1;
        up_btn = u;
        cyc(1);
        load = 1'b0;
        up_btn = 1'b0;
    endtask

    function automatic logic [63:0] now();
        return {8'h00, year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd};
    endfunction

    logic [55:0] ld [9] = '{56'h2024_02_28_23_59_59, 56'h2100_02_28_23_59_59,
                            56'h9999_12_31_23_59_59, 56'h2000_02_28_23_59_59,
                            56'h2023_02_28_23_59_59, 56'h2024_02_29_23_59_59,
                            56'h2023_02_31_10_00_00, 56'h2023_04_30_23_59_59,
                            56'h2023_12_31_23_59_59};
    logic [55:0] ldx [9] = '{56'h2024_02_28_23_59_59, 56'h2100_02_28_23_59_59,
                             56'h9999_12_31_23_59_59, 56'h2000_02_28_23_59_59,
                             56'h2023_02_28_23_59_59, 56'h2024_02_29_23_59_59,
                             56'h2023_02_28_10_00_00, 56'h2023_04_30_23_59_59,
                             56'h2023_12_31_23_59_59};
    logic [55:0] tk [9] = '{56'h2024_02_29_00_00_00, 56'h2100_03_01_00_00_00,
                            56'h0000_01_01_00_00_00, 56'h2000_02_29_00_00_00,
                            56'h2023_03_01_00_00_00, 56'h2024_03_01_00_00_00,
                            56'h2023_02_28_10_00_01, 56'h2023_05_01_00_00_00,
                            56'h2024_01_01_00_00_00};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        {load, mode_btn, adjust_btn, up_btn, down_btn, alarm_on} = 6'b0;
        {load_year_bcd, load_month_bcd, load_day_bcd} = '0;
        {load_hour_bcd, load_minute_bcd, load_second_bcd} = '0;
        cyc(2);
        chk("reset_time", now(), 56'h2000_01_01_00_00_00);
        chk("reset_tick", sec_tick, 0);
        chk("reset_edit", edit_active, 0);
        chk("reset_field", edit_field, 0);
        chk("reset_alarm", alarm_hit, 0);
        reset_n = 1'b1;
        cyc(3);
        chk("pre_tick_sec", second_bcd, 8'h00);
        chk("pre_tick", sec_tick, 0);
        cyc(1);
        chk("first_tick_sec", second_bcd, 8'h01);
        chk("first_tick", sec_tick, 1);
        cyc(1);
        chk("tick_one_cycle", sec_tick, 0);
        cyc(955);
        chk("240_ticks", now(), 56'h2000_01_01_00_04_00);

        press(0, 1, 0, 0);
        t0 = ticks;
        chk("enter_edit", edit_active, 1);
        chk("enter_field", edit_field, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        chk("field_day", edit_field, 2);
        press(0, 0, 1, 0);
        chk("day_up", day_bcd, 8'h02);
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        chk("day_wrap_down", day_bcd, 8'h31);
        cyc(10);
        chk("edit_no_ticks", ticks, t0);
        chk("edit_hold", now(), 56'h2000_01_31_00_04_00);
        press(0, 1, 0, 0);
        chk("exit_edit", edit_active, 0);
        cyc(3);
        chk("exit_pre_tick", sec_tick, 0);
        cyc(1);
        chk("exit_tick", sec_tick, 1);
        chk("exit_tick_sec", second_bcd, 8'h01);

        cyc(3);
        do_load(56'h2010_06_15_08_09_10, 1'b1);
        chk("load_prio_time", now(), 56'h2010_06_15_08_09_10);
        chk("load_prio_tick", sec_tick, 0);
        chk("load_prio_run", edit_active, 0);
        cyc(4);
        chk("load_presc_clr", second_bcd, 8'h11);

        for (int i = 0; i < 9; i++) begin
            do_load(ld[i], 1'b0);
            chk($sformatf("load_%0d", i), now(), ldx[i]);
            cyc(4);
            chk($sformatf("roll_%0d", i), now(), tk[i]);
            chk($sformatf("roll_alarm_%0d", i), alarm_hit, 0);
        end

        do_load(56'h2023_01_31_12_00_00, 1'b0);
        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        chk("field_month", edit_field, 1);
        press(0, 0, 1, 0);
        chk("month_clamp_2023", now(), 56'h2023_02_28_12_00_00);
        press(0, 0, 1, 1);
        chk("up_down_nochange", now(), 56'h2023_02_28_12_00_00);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        chk("hour_down", now(), 56'h2023_02_28_11_00_00);
        press(1, 1, 0, 0);
        chk("adjust_beats_mode", {edit_active, edit_field}, {1'b0, 3'd3});

        do_load(56'h2024_01_31_00_00_00, 1'b0);
        press(0, 1, 0, 0);
        for (int i = 0; i < NF; i++) press(1, 0, 0, 0);
        chk("field_wrap", edit_field, 0);
        press(0, 0, 0, 1);
        chk("year_down", year_bcd, 16'h2023);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        chk("month_clamp_2024", now(), 56'h2024_02_29_00_00_00);
        do_load(56'h2011_11_11_11_11_11, 1'b1);
        chk("load_in_edit", {edit_active, now()}, {1'b0, 64'h2011_11_11_11_11_11});

        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_time", now(), 56'h2000_01_01_00_00_00);
        chk("async_reset_state", {edit_active, edit_field, sec_tick}, 0);
        cyc(1);
        reset_n = 1'b1;
        cyc(3);
        chk("post_reset_pre", second_bcd, 8'h00);
        cyc(1);
        chk("post_reset_tick", now(), 56'h2000_01_01_00_00_01);

`ifdef CALENDAR_RTC_ALARM_EN
        press(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) press(1, 0, 0, 0);
        chk("field_alarm_hour", edit_field, 6);
        for (int i = 0; i < 7; i++) press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        alarm_on = 1'b1;
        do_load(56'h2024_05_05_07_29_59, 1'b0);
        chk("alarm_after_load", alarm_hit, 0);
        cyc(3);
        chk("alarm_pre", alarm_hit, 0);
        cyc(1);
        chk("alarm_time", now(), 56'h2024_05_05_07_30_00);
        chk("alarm_hit", alarm_hit, 1);
        cyc(1);
        chk("alarm_one_cycle", alarm_hit, 0);
        alarm_on = 1'b0;
        do_load(56'h2024_05_05_07_29_59, 1'b0);
        cyc(4);
        chk("alarm_off", alarm_hit, 0);
        alarm_on = 1'b1;
        do_load(56'h2024_05_05_07_30_00, 1'b0);
        chk("alarm_direct_load", alarm_hit, 0);
        cyc(1);
        chk("alarm_direct_load2", alarm_hit, 0);
        alarm_on = 1'b0;
`else
        alarm_on = 1'b1;
        do_load(56'h2024_05_05_23_59_59, 1'b0);
        cyc(4);
        chk("no_alarm_build", {alarm_hit, now()}, {1'b0, 64'h2024_05_06_00_00_00});
        alarm_on = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
